// File: rtl/memgame_round_ctrl.sv
`default_nettype none
// memgame_round_ctrl: memory-game round sequencer -- LFSR digit generation, timed
// playback on led, edge-detected player entries and the advance/win/lose decision.
module memgame_round_ctrl #(
    parameter int         MAX_LEN     = 8,
    parameter int         SHOW_CYCLES = 50,
    parameter int         GAP_CYCLES  = 10,
    parameter logic [7:0] SEED        = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startIN,
    input  logic       loadIN,
    input  logic [3:0] predict,
    output logic [7:0] led,
    output logic [3:0] level,
    output logic       busy,
    output logic       win,
    output logic       lose
);
    localparam int MAX_CYC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       MAX_LEN_V = 4'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GEN     = 3'd1,
        S_SHOW    = 3'd2,
        S_GAP     = 3'd3,
        S_WAIT_IN = 3'd4,
        S_WIN     = 3'd5,
        S_LOSE    = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [3:0]       level_q, level_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             loadin_q;
    logic [3:0]       mem_q [MAX_LEN];
    logic             mem_we;

    logic [7:0] lfsr_next;
    logic [3:0] level_m1;
    logic [3:0] cur_digit;
    logic       entry;

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign level_m1  = level_q - 4'd1;
    // Rising edge of the button; loadin_q follows loadIN in every state.
    assign entry     = loadIN & ~loadin_q;

    always_comb begin
        cur_digit = 4'h0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 4'(i)) cur_digit = mem_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED;
            level_q  <= 4'd1;
            idx_q    <= 4'd0;
            cnt_q    <= '0;
            loadin_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= 4'h0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            level_q  <= level_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            loadin_q <= loadIN;
            for (int i = 0; i < MAX_LEN; i++) begin
                if (mem_we && level_m1 == 4'(i)) mem_q[i] <= lfsr_next[3:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        level_d = level_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                level_d = 4'd1;
                idx_d   = 4'd0;
                cnt_d   = '0;
                if (startIN) state_d = S_GEN;
            end
            S_GEN: begin
                lfsr_d  = lfsr_next;
                mem_we  = 1'b1;
                idx_d   = 4'd0;
                cnt_d   = '0;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == level_m1) begin
                        idx_d   = 4'd0;
                        state_d = S_WAIT_IN;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_SHOW;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_IN: begin
                if (entry) begin
                    if (predict != cur_digit) begin
                        state_d = S_LOSE;
                    end else if (idx_q != level_m1) begin
                        idx_d = idx_q + 4'd1;
                    end else if (level_q == MAX_LEN_V) begin
                        state_d = S_WIN;
                    end else begin
                        level_d = level_q + 4'd1;
                        state_d = S_GEN;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (!startIN) begin
                    level_d = 4'd1;
                    idx_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        led = 8'h00;
        case (state_q)
            S_SHOW:    led = {1'b1, 3'b000, cur_digit};
            S_WAIT_IN: led = 8'h40;
            S_WIN:     led = 8'hFF;
            S_LOSE:    led = 8'h0F;
            default:   led = 8'h00;
        endcase
    end

    assign level = level_q;
    assign busy  = (state_q != S_IDLE);
    assign win   = (state_q == S_WIN);
    assign lose  = (state_q == S_LOSE);

endmodule
`default_nettype wire

// File: tb/tb_memgame_round_ctrl.sv
`default_nettype none
// Randomized game-level bench: expected output segments (value, duration) are queued
// by the driver and matched against observed runs of constant outputs by a monitor.
module tb_memgame_round_ctrl;
    localparam int         MAX_LEN = 8;
    localparam int         SHOW_C  = 50;
    localparam int         GAP_C   = 10;
    localparam logic [7:0] SEED    = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       startIN = 1'b0;
    logic       loadIN = 1'b0;
    logic [3:0] predict = 4'h0;
    logic [7:0] led;
    logic [3:0] level;
    logic       busy, win, lose;

    memgame_round_ctrl #(
        .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW_C), .GAP_CYCLES(GAP_C), .SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .startIN(startIN), .loadIN(loadIN), .predict(predict),
        .led(led), .level(level), .busy(busy), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] val;
        int          len;   // 0: duration depends on stimulus, not checked
    } seg_t;

    seg_t        exp_q[$];
    int          checks = 0;
    int          fails = 0;
    logic        mon_en = 1'b0;
    logic        have_run = 1'b0;
    logic [14:0] run_val;
    int          run_len;

    logic [7:0] m_lfsr;
    logic [3:0] seq[$];
    int         m_level;

    function automatic logic [14:0] tup(input logic [7:0] l, input int lv,
                                        input bit b, input bit w, input bit ls);
        logic [3:0] lv4;
        lv4 = lv[3:0];
        return {l, lv4, b, w, ls};
    endfunction

    function automatic string fmt(input logic [14:0] v);
        return $sformatf("led=%h level=%0d busy=%b win=%b lose=%b",
                         v[14:7], v[6:3], v[2], v[1], v[0]);
    endfunction

    task automatic push(input logic [7:0] l, input int lv, input bit b, input bit w,
                        input bit ls, input int len);
        seg_t s;
        s.val = tup(l, lv, b, w, ls);
        s.len = len;
        exp_q.push_back(s);
    endtask

    task automatic close_run();
        seg_t e;
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_segment: got %s for %0d cycles, nothing expected",
                     fmt(run_val), run_len);
        end else begin
            e = exp_q.pop_front();
            if (run_val !== e.val) begin
                fails++;
                $display("FAIL seg_value: got %s, want %s", fmt(run_val), fmt(e.val));
            end
            if (e.len != 0) begin
                checks++;
                if (run_len != e.len) begin
                    fails++;
                    $display("FAIL seg_length (%s): got %0d cycles, want %0d",
                             fmt(e.val), run_len, e.len);
                end
            end
        end
    endtask

    // Monitor: every change of the output tuple closes the previous run.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!have_run) begin
                run_val  = {led, level, busy, win, lose};
                run_len  = 1;
                have_run = 1'b1;
            end else if ({led, level, busy, win, lose} === run_val) begin
                run_len++;
            end else begin
                close_run();
                run_val = {led, level, busy, win, lose};
                run_len = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic summary_and_finish();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    endtask

    task automatic wait_led(input logic [7:0] val, input int bound);
        int n = 0;
        while (led !== val && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (led !== val) begin
            fails++;
            $display("FAIL timeout_led: got led=%h after %0d cycles, want %h", led, n, val);
            summary_and_finish();
        end
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_idle: got busy=%b after %0d cycles, want 0", busy, n);
            summary_and_finish();
        end
    endtask

    // Reference sequence: one LFSR step per new round, low nibble is the digit.
    task automatic new_digit();
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
        seq.push_back(m_lfsr[3:0]);
    endtask

    task automatic push_round();
        push(8'h00, m_level, 1, 0, 0, 1);
        for (int i = 0; i < m_level; i++) begin
            push(8'h80 | {4'h0, seq[i]}, m_level, 1, 0, 0, SHOW_C);
            push(8'h00, m_level, 1, 0, 0, GAP_C);
        end
        push(8'h40, m_level, 1, 0, 0, 0);
    endtask

    task automatic stroke(input logic [3:0] p, input bit term);
        bit hold_start;
        repeat ($urandom_range(1, 3)) tick();
        hold_start = term && ($urandom_range(0, 1) == 1);
        predict = p;
        loadIN  = 1'b1;
        startIN = hold_start;
        repeat ($urandom_range(1, 20)) tick();
        loadIN = 1'b0;
        if (hold_start) begin
            repeat ($urandom_range(0, 3)) tick();
            startIN = 1'b0;
        end
    endtask

    task automatic play_game(input bit clean, input bit hold_across, input int lose_at);
        bit done = 0;
        seq.delete();
        m_level = 1;
        new_digit();
        push_round();
        if (hold_across) begin
            loadIN  = 1'b1;
            predict = seq[0] ^ 4'hF;
        end
        startIN = 1'b1;
        tick();
        startIN = 1'b0;
        wait_led(8'h40, m_level * (SHOW_C + GAP_C) + 5);
        if (hold_across) begin
            repeat (2) tick();
            loadIN = 1'b0;
            tick();
        end
        while (!done) begin
            for (int i = 0; i < m_level; i++) begin
                bit         wrong, last, won;
                logic [3:0] p;
                last  = (i == m_level - 1);
                wrong = (last && m_level == lose_at) ||
                        (!clean && $urandom_range(0, 15) == 0);
                won   = !wrong && last && (m_level == MAX_LEN);
                p     = wrong ? (seq[i] ^ 4'($urandom_range(1, 15))) : seq[i];
                if (wrong) begin
                    push(8'h0F, m_level, 1, 0, 1, 0);
                    push(8'h00, 1, 0, 0, 0, 0);
                end else if (won) begin
                    push(8'hFF, MAX_LEN, 1, 1, 0, 0);
                    push(8'h00, 1, 0, 0, 0, 0);
                end else if (last) begin
                    m_level++;
                    new_digit();
                    push_round();
                end
                stroke(p, wrong || won);
                if (wrong || won) begin
                    done = 1;
                    break;
                end
                if (last) begin
                    wait_led(8'h40, m_level * (SHOW_C + GAP_C) + 5);
                    break;
                end
            end
        end
        wait_idle(30);
        repeat ($urandom_range(1, 5)) tick();
    endtask

    task automatic reset_mid_show();
        int r;
        seq.delete();
        m_level = 1;
        new_digit();
        r = $urandom_range(1, SHOW_C - 1);
        push(8'h00, 1, 1, 0, 0, 1);
        push(8'h80 | {4'h0, seq[0]}, 1, 1, 0, 0, r);
        push(8'h00, 1, 0, 0, 0, 0);
        startIN = 1'b1;
        tick();
        startIN = 1'b0;
        repeat (r) tick();
        reset = 1'b0;
        repeat (2) tick();
        reset  = 1'b1;
        m_lfsr = SEED;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            startIN = 1'($urandom_range(0, 1));
            loadIN  = 1'($urandom_range(0, 1));
            predict = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if ({led, level, busy, win, lose} !== tup(8'h00, 1, 0, 0, 0)) begin
                fails++;
                $display("FAIL reset_state: got %s, want %s",
                         fmt({led, level, busy, win, lose}), fmt(tup(8'h00, 1, 0, 0, 0)));
            end
        end
        startIN = 1'b0;
        loadIN  = 1'b0;
        predict = 4'h0;
        reset   = 1'b1;
        m_lfsr  = SEED;
        push(8'h00, 1, 0, 0, 0, 0);
        mon_en  = 1'b1;
        repeat (10) tick();

        play_game(1, 0, 0);
        play_game(0, 1, 2);
        play_game(0, 0, 0);
        reset_mid_show();
        play_game(0, 1, 0);
        play_game(1, 0, 0);
        for (int g = 0; g < 4; g++) begin
            play_game(0, ($urandom_range(0, 2) == 0), 0);
        end

        repeat (3) tick();
        mon_en = 1'b0;
        if (have_run) close_run();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_segments: got %0d unobserved, want 0", exp_q.size());
        end
        summary_and_finish();
    end

endmodule
`default_nettype wire
